// File: rtl/lamp_frame_ctrl.sv
// Frame-rate tick, animation time base, host write staging into the next-target buffer
// and commit-driven next->target copy. Define LAMP_OVERRUN_CNT_EN to add o_overrun_cnt.
module lamp_frame_ctrl #(
  parameter  int c_ledboards    = 30,
  parameter  int c_bpc          = 12,
  parameter  int c_max_time     = 1024,
  parameter  int c_frame_period = 16666,
  localparam int c_channels     = c_ledboards * 32,
  localparam int c_addr_w       = $clog2(c_channels),
  localparam int c_time_w       = $clog2(c_max_time)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wen,
  input  logic [c_addr_w-1:0] i_waddr,
  input  logic [c_bpc-1:0]    i_wdata,
  input  logic                i_commit,
  input  logic [c_time_w-1:0] i_duration,
  output logic                o_ready,
  output logic                o_next_wen,
  output logic [c_addr_w-1:0] o_next_waddr,
  output logic [c_bpc-1:0]    o_next_wdata,
  output logic [c_addr_w-1:0] o_next_raddr,
  input  logic [c_bpc-1:0]    i_next_rdata,
  output logic                o_tgt_wen,
  output logic [c_addr_w-1:0] o_tgt_waddr,
  output logic [c_bpc-1:0]    o_tgt_wdata,
  output logic                o_drq,
  output logic [c_time_w-1:0] o_time,
  output logic [c_time_w-1:0] o_start_time,
  output logic [c_time_w-1:0] o_target_time,
`ifdef LAMP_OVERRUN_CNT_EN
  output logic [7:0]          o_overrun_cnt,
`endif
  output logic                o_animating
);

  localparam int c_tick_w = $clog2(c_frame_period);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(c_frame_period - 1);
  localparam logic [c_cnt_w-1:0]  c_copy_last = c_cnt_w'(c_channels);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_COPY, S_ANIM} state_t;

  typedef struct packed {
    logic                wen;
    logic [c_addr_w-1:0] addr;
    logic [c_bpc-1:0]    data;
  } host_wr_t;

  state_t              state_q, state_d;
  logic [c_tick_w-1:0] tick_q;
  logic [c_time_w-1:0] time_q, dur_q, start_q, target_q;
  logic [c_cnt_w-1:0]  copy_cnt;
  logic [c_addr_w-1:0] tgt_addr_q;
  logic                tgt_vld_q;
  logic                anim_q;
  host_wr_t            wr_q;
  logic                drq, ready, rd_issue, commit_acc, copy_last, anim_done;

  // Frame tick and time base
  assign drq = (tick_q == c_tick_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q <= '0;
      time_q <= '0;
    end else if (drq) begin
      tick_q <= '0;
      time_q <= time_q + 1'b1;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  assign commit_acc = i_commit & ready;
  assign copy_last  = (copy_cnt == c_copy_last);
  assign anim_done  = drq && (time_q == target_q);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state; a commit during ANIM preempts the running transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (commit_acc) state_d = S_PEND;
      S_PEND: if (drq) state_d = S_COPY;
      S_COPY: if (copy_last) state_d = S_ANIM;
      S_ANIM: begin
        if (commit_acc)     state_d = S_PEND;
        else if (anim_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready    = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      S_IDLE, S_ANIM: ready = 1'b1;
      S_COPY:         rd_issue = !copy_last;
      default: ;
    endcase
  end

  // Copy sequencer: read slot k, write target slot k one cycle later
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      copy_cnt   <= '0;
      tgt_vld_q  <= 1'b0;
      tgt_addr_q <= '0;
    end else begin
      copy_cnt  <= (state_q == S_COPY) ? copy_cnt + 1'b1 : '0;
      tgt_vld_q <= rd_issue;
      if (rd_issue) tgt_addr_q <= copy_cnt[c_addr_w-1:0];
    end
  end

  // Animation window; o_animating is held across a preempting commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dur_q    <= '0;
      start_q  <= '0;
      target_q <= '0;
      anim_q   <= 1'b0;
    end else begin
      if (commit_acc) dur_q <= i_duration;
      if (state_q == S_COPY && copy_last) begin
        start_q  <= time_q;
        target_q <= time_q + dur_q;
        anim_q   <= 1'b1;
      end else if (state_q == S_ANIM && !commit_acc && anim_done) begin
        anim_q <= 1'b0;
      end
    end
  end

  // Host write staging, dropped while busy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q <= '0;
    end else begin
      wr_q.wen <= i_wen & ready;
      if (ready) begin
        wr_q.addr <= i_waddr;
        wr_q.data <= i_wdata;
      end
    end
  end

`ifdef LAMP_OVERRUN_CNT_EN
  logic [1:0] drop_n;
  logic [7:0] ovr_q;

  assign drop_n = {1'b0, i_commit & ~ready} + {1'b0, i_wen & ~ready};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                               ovr_q <= '0;
    else if (ovr_q > (8'd255 - {6'd0, drop_n})) ovr_q <= 8'd255;
    else                                        ovr_q <= ovr_q + {6'd0, drop_n};
  end

  assign o_overrun_cnt = ovr_q;
`endif

  assign o_ready       = ready;
  assign o_next_wen    = wr_q.wen;
  assign o_next_waddr  = wr_q.addr;
  assign o_next_wdata  = wr_q.data;
  assign o_next_raddr  = rd_issue ? copy_cnt[c_addr_w-1:0] : '0;
  assign o_tgt_wen     = tgt_vld_q;
  assign o_tgt_waddr   = tgt_addr_q;
  assign o_tgt_wdata   = tgt_vld_q ? i_next_rdata : '0;
  assign o_drq         = drq;
  assign o_time        = time_q;
  assign o_start_time  = start_q;
  assign o_target_time = target_q;
  assign o_animating   = anim_q;

endmodule

// File: tb/tb_lamp_frame_ctrl.sv
// Directed bench for lamp_frame_ctrl: 32 channels, 64-cycle frames, time modulus 1024.
module tb_lamp_frame_ctrl;
  localparam int FP = 64, MT = 1024, CH = 32, AW = 5, TW = 10, BPC = 12;

  typedef struct { int addr; int data; } sb_ent_t;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           wen, commit;
  logic [AW-1:0]  waddr;
  logic [BPC-1:0] wdata;
  logic [TW-1:0]  dur;
  logic           ready, next_wen, tgt_wen, drq, anim;
  logic [AW-1:0]  next_waddr, next_raddr, tgt_waddr;
  logic [BPC-1:0] next_wdata, tgt_wdata, next_rdata;
  logic [TW-1:0]  tm, start_t, target_t;
`ifdef LAMP_OVERRUN_CNT_EN
  logic [7:0]     ovr;
`endif

  int             checks = 0, fails = 0, cyc = 0, copy_c0 = 0;
  bit             mdl_on = 1'b0;
  sb_ent_t        sb[$];
  logic [BPC-1:0] shadow [CH];
  logic [BPC-1:0] nbuf [CH];

  always #5 clk = ~clk;

  lamp_frame_ctrl #(
    .c_ledboards(1), .c_bpc(BPC), .c_max_time(MT), .c_frame_period(FP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_commit(commit), .i_duration(dur),
    .o_ready(ready),
    .o_next_wen(next_wen), .o_next_waddr(next_waddr), .o_next_wdata(next_wdata),
    .o_next_raddr(next_raddr), .i_next_rdata(next_rdata),
    .o_tgt_wen(tgt_wen), .o_tgt_waddr(tgt_waddr), .o_tgt_wdata(tgt_wdata),
    .o_drq(drq), .o_time(tm), .o_start_time(start_t), .o_target_time(target_t),
`ifdef LAMP_OVERRUN_CNT_EN
    .o_overrun_cnt(ovr),
`endif
    .o_animating(anim)
  );

  // Next-target RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (next_wen) nbuf[next_waddr] <= next_wdata;
    next_rdata <= nbuf[next_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; frame tick/time checked against the cycle count, target writes against the scoreboard
  task automatic step();
    sb_ent_t e;
    @(posedge clk);
    #1;
    if (!mdl_on) return;
    cyc++;
    chk("drq", 32'(drq), 32'((cyc % FP) == FP - 1));
    chk("time", 32'(tm), (cyc / FP) % MT);
    if (tgt_wen) begin
      if (sb.size() == 0) chk("tgt_spurious", 32'(tgt_wen), 0);
      else begin
        e = sb.pop_front();
        chk("tgt_addr", 32'(tgt_waddr), e.addr);
        chk("tgt_data", 32'(tgt_wdata), e.data);
        chk("tgt_cycle", cyc, copy_c0 + 1 + e.addr);
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic host_write(input int a, input int d);
    wen = 1'b1; waddr = AW'(a); wdata = BPC'(d); shadow[a] = BPC'(d);
    step();
    wen = 1'b0;
    chk("next_wen", 32'(next_wen), 1);
    chk("next_waddr", 32'(next_waddr), a);
    chk("next_wdata", 32'(next_wdata), d);
  endtask

  // Commit outside a tick cycle; COPY then begins the cycle after the next tick
  task automatic do_commit(input int d, output int c0);
    if (cyc % FP == FP - 1) step();
    chk("commit_ready", 32'(ready), 1);
    commit = 1'b1; dur = TW'(d);
    for (int k = 0; k < CH; k++) sb.push_back('{k, int'(shadow[k])});
    c0 = (cyc / FP) * FP + FP;
    copy_c0 = c0;
    step();
    commit = 1'b0;
    chk("commit_busy", 32'(ready), 0);
  endtask

  // Animation must stay high through the tick at time tgt and drop right after it
  task automatic anim_fall(input string tag, input int tgt);
    int tc;
    tc = (cyc / FP) * FP + FP - 1;
    for (int i = 0; i < MT && ((tc / FP) % MT) != tgt; i++) tc += FP;
    wait_until(tc);
    chk({tag, "_anim_at_last_tick"}, 32'(anim), 1);
    step();
    chk({tag, "_anim_fell"}, 32'(anim), 0);
    chk({tag, "_ready_idle"}, 32'(ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_drq"}, 32'(drq), 0);
    chk({tag, "_time"}, 32'(tm), 0);
    chk({tag, "_start"}, 32'(start_t), 0);
    chk({tag, "_target"}, 32'(target_t), 0);
    chk({tag, "_anim"}, 32'(anim), 0);
    chk({tag, "_next_wen"}, 32'(next_wen), 0);
    chk({tag, "_next_waddr"}, 32'(next_waddr), 0);
    chk({tag, "_next_wdata"}, 32'(next_wdata), 0);
    chk({tag, "_next_raddr"}, 32'(next_raddr), 0);
    chk({tag, "_tgt_wen"}, 32'(tgt_wen), 0);
    chk({tag, "_tgt_waddr"}, 32'(tgt_waddr), 0);
    chk({tag, "_tgt_wdata"}, 32'(tgt_wdata), 0);
  endtask

  initial begin
    int c0, t;
    logic dropped;
    wen = 1'b0; waddr = '0; wdata = '0; commit = 1'b0; dur = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; mdl_on = 1'b1; cyc = 0;
    check_reset_outputs("por");

    // 1: reset asserted while PEND, then tick/time from release
    host_write(7, 5);
    do_commit(4, c0);
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    mdl_on = 1'b0; sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1; cyc = 0; mdl_on = 1'b1;
    wait_until(FP - 1);
    chk("t1_first_drq", 32'(drq), 1);
    step();
    chk("t1_time_after_tick", 32'(tm), 1);

    // 2: fill next-target, commit duration 10
    for (int k = 0; k < CH; k++) host_write(k, 3 * k);
    do_commit(10, c0);
    t = (c0 / FP) % MT;
    wait_until(c0 + CH);
    chk("t2_ready_copy_last", 32'(ready), 0);
    step();
    chk("t2_sb_drained", sb.size(), 0);
    chk("t2_start", 32'(start_t), t);
    chk("t2_target", 32'(target_t), (t + 10) % MT);
    chk("t2_anim", 32'(anim), 1);
    chk("t2_ready", 32'(ready), 1);
    anim_fall("t2", (t + 10) % MT);

    // 3: commit and write during COPY are dropped
    host_write(0, 12'h7ff);
    host_write(5, 12'h123);
    do_commit(3, c0);
    t = (c0 / FP) % MT;
    wait_until(c0 + 2);
    commit = 1'b1; dur = TW'(7);
    step();
    commit = 1'b0;
    wen = 1'b1; waddr = AW'(31); wdata = 12'habc;
    step();
    wen = 1'b0;
    chk("t3_drop_wen", 32'(next_wen), 0);
    wait_until(c0 + CH + 1);
    chk("t3_sb_drained", sb.size(), 0);
    chk("t3_start", 32'(start_t), t);
    chk("t3_target", 32'(target_t), (t + 3) % MT);
`ifdef LAMP_OVERRUN_CNT_EN
    chk("t3_overrun", 32'(ovr), 2);
`endif
    anim_fall("t3", (t + 3) % MT);

    // 4: preempt a 10-tick animation at its 5th tick with duration 20
    do_commit(10, c0);
    t = (c0 / FP) % MT;
    wait_until(c0 + 5 * FP + 10);
    chk("t4_anim_before", 32'(anim), 1);
    do_commit(20, c0);
    dropped = 1'b0;
    while (cyc < c0 + CH + 1) begin
      step();
      if (anim !== 1'b1) dropped = 1'b1;
    end
    chk("t4_anim_held", 32'(dropped), 0);
    chk("t4_sb_drained", sb.size(), 0);
    chk("t4_start", 32'(start_t), (t + 6) % MT);
    chk("t4_target", 32'(target_t), (t + 26) % MT);
    anim_fall("t4", (t + 26) % MT);

    // 6: duration 0
    do_commit(0, c0);
    t = (c0 / FP) % MT;
    wait_until(c0 + CH + 1);
    chk("t6_start", 32'(start_t), t);
    chk("t6_target", 32'(target_t), t);
    chk("t6_anim", 32'(anim), 1);
    anim_fall("t6", t);

    // 5: commit at time 1019 -> start 1020, target wraps to 6
    wait_until(1019 * FP + 10);
    do_commit(10, c0);
    wait_until(c0 + CH + 1);
    chk("t5_sb_drained", sb.size(), 0);
    chk("t5_start", 32'(start_t), 1020);
    chk("t5_target", 32'(target_t), 6);
    anim_fall("t5", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
